// File: rtl/clk_period_meter.sv
//-----------------------------------------------------------------------------
// clk_period_meter
//
// Measures the period of a slow square wave in clk_in cycles. The wave is
// synchronised, rising edges are detected, and the number of cycles between
// consecutive rising edges is captured into a one-entry output buffer that is
// drained over a valid/ready handshake.
//
// Parameters
//   WIDTH        divider load width; the period is PW = WIDTH+2 bits wide
//   SYNC_STAGES  synchroniser depth on sig_in (2..4)
//
// Ports
//   clk_in        single clock, all logic on posedge
//   rst_n         asynchronous active-low reset
//   sig_in        wave to measure, asynchronous to clk_in
//   enable        1 = measure, 0 = abort to IDLE and clear the count
//   period_out    captured period in clk_in cycles
//   period_valid  period_out holds an unconsumed measurement
//   period_ready  consumer accepts when valid && ready
//   period_ovf    captured count was saturated
//   stalled       live count is saturated (no edge seen for 2^PW-1 cycles)
//   dropped       sticky: a capture was discarded because the buffer was full
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module clk_period_meter #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    output logic [WIDTH+1:0] period_out,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             period_ovf,
    output logic             stalled,
    output logic             dropped
);

    localparam int            PW      = WIDTH + 2;
    localparam logic [PW-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0] CNT_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    //-------------------------------------------------------------------------
    // Synchroniser plus one delay flop for edge detection
    //-------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   d_reg;
    logic                   rise;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            d_reg    <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
            d_reg    <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~d_reg;

    //-------------------------------------------------------------------------
    // Measurement FSM and saturating counter
    //-------------------------------------------------------------------------
    state_t         state_reg, state_next;
    logic [PW-1:0]  cnt_reg, cnt_next;
    logic           capture;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        if (!enable) begin
            // enable has priority over a rise arriving in the same cycle
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_next   = '0;
                    state_next = ARM;
                end
                ARM: begin
                    // First edge only starts the count; nothing is captured
                    if (rise) begin
                        cnt_next   = CNT_ONE;
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // cnt holds the number of cycles since the last rise
                        capture  = 1'b1;
                        cnt_next = CNT_ONE;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    //-------------------------------------------------------------------------
    // One-entry output buffer
    //-------------------------------------------------------------------------
    logic [PW-1:0] out_reg;
    logic          valid_reg;
    logic          ovf_reg;
    logic          dropped_reg;
    logic          load;

    // A capture is accepted when the buffer is empty or is being drained in
    // this very cycle; otherwise the old value is kept and the new one lost.
    assign load = capture & (~valid_reg | period_ready);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            out_reg   <= '0;
            ovf_reg   <= 1'b0;
            valid_reg <= 1'b0;
        end else if (load) begin
            out_reg   <= cnt_reg;
            ovf_reg   <= (cnt_reg == CNT_MAX);
            valid_reg <= 1'b1;
        end else if (valid_reg && period_ready) begin
            valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            dropped_reg <= 1'b0;
        end else if (!enable) begin
            dropped_reg <= 1'b0;
        end else if (capture && valid_reg && !period_ready) begin
            dropped_reg <= 1'b1;
        end
    end

    assign period_out   = out_reg;
    assign period_valid = valid_reg;
    assign period_ovf   = ovf_reg;
    assign dropped      = dropped_reg;
    assign stalled      = (state_reg == MEASURE) && (cnt_reg == CNT_MAX);

endmodule

// File: tb/tb_clk_period_meter.sv
//-----------------------------------------------------------------------------
// tb_clk_period_meter
//
// Three meters share one set of inputs:
//   u0: WIDTH=24, SYNC_STAGES=2   u1: WIDTH=2, SYNC_STAGES=3
//   u2: WIDTH=2,  SYNC_STAGES=4
// A behavioural model tracks each meter from edge timestamps: the period is
// the distance between successive acted-on rises, saturated at 2^PW-1.
// Directed phases pin the model with literal values; a random phase follows.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_period_meter;

    logic clk_in;
    logic rst_n;
    logic sig_in;
    logic enable;
    logic period_ready;

    logic [25:0] p_out0;
    logic [3:0]  p_out1;
    logic [3:0]  p_out2;
    logic [2:0]  p_valid;
    logic [2:0]  p_ovf;
    logic [2:0]  p_stalled;
    logic [2:0]  p_dropped;
    logic [2:0]  rise_w;

    clk_period_meter #(.WIDTH(24), .SYNC_STAGES(2)) u0 (
        .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .period_out(p_out0), .period_valid(p_valid[0]), .period_ready(period_ready),
        .period_ovf(p_ovf[0]), .stalled(p_stalled[0]), .dropped(p_dropped[0]));

    clk_period_meter #(.WIDTH(2), .SYNC_STAGES(3)) u1 (
        .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .period_out(p_out1), .period_valid(p_valid[1]), .period_ready(period_ready),
        .period_ovf(p_ovf[1]), .stalled(p_stalled[1]), .dropped(p_dropped[1]));

    clk_period_meter #(.WIDTH(2), .SYNC_STAGES(4)) u2 (
        .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .period_out(p_out2), .period_valid(p_valid[2]), .period_ready(period_ready),
        .period_ovf(p_ovf[2]), .stalled(p_stalled[2]), .dropped(p_dropped[2]));

    assign rise_w = {u2.rise, u1.rise, u0.rise};

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    //-------------------------------------------------------------------------
    // Helpers
    //-------------------------------------------------------------------------
    function automatic longint get_out(input int i);
        case (i)
            0:       return longint'(p_out0);
            1:       return longint'(p_out1);
            default: return longint'(p_out2);
        endcase
    endfunction

    task automatic chk(input string name, input int inst, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[u%0d] @%0t: got %0d, want %0d", name, inst, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic sig_period(input int hi, input int lo);
        sig_in = 1'b1;
        cyc(hi);
        sig_in = 1'b0;
        cyc(lo);
    endtask

    task automatic expect_buf(input int i, input longint v, input longint o, input longint dr);
        chk("valid", i, longint'(p_valid[i]), v);
        if (v != 0) chk("period_out", i, get_out(i), o);
        chk("dropped", i, longint'(p_dropped[i]), dr);
    endtask

    //-------------------------------------------------------------------------
    // Behavioural model
    //-------------------------------------------------------------------------
    int     s_of[3]   = '{2, 3, 4};
    longint max_of[3] = '{longint'(67108863), longint'(15), longint'(15)};

    bit     hist[$];            // sig_in as sampled at each posedge, newest first
    longint u;                  // posedge counter
    int     m_mode[3];          // 0 idle, 1 armed, 2 measuring
    longint m_last[3];          // posedge at which the previous rise was acted on
    bit     m_valid[3];
    longint m_out[3];
    bit     m_ovf[3];
    bit     m_drop[3];
    bit     m_stall[3];
    bit     m_rise[3];          // rise the next posedge will act on

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < 8; k++) hist.push_front(1'b0);
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_last[i] = 0; m_valid[i] = 0; m_out[i] = 0;
            m_ovf[i] = 0; m_drop[i] = 0; m_stall[i] = 0; m_rise[i] = 0;
        end
    endtask

    task automatic model_step();
        u++;
        hist.push_front(sig_in);
        if (hist.size() > 16) void'(hist.pop_back());
        for (int i = 0; i < 3; i++) begin
            int     s;
            bit     r;
            bit     cap;
            longint per;
            s   = s_of[i];
            r   = hist[s] & ~hist[s+1];
            cap = 1'b0;
            per = 0;
            if (!enable) begin
                m_mode[i] = 0;
                m_drop[i] = 1'b0;
            end else begin
                case (m_mode[i])
                    0: m_mode[i] = 1;
                    1: if (r) begin m_mode[i] = 2; m_last[i] = u; end
                    default: if (r) begin
                        cap = 1'b1;
                        per = u - m_last[i];
                        if (per > max_of[i]) per = max_of[i];
                        m_last[i] = u;
                    end
                endcase
            end
            if (cap) begin
                if (!m_valid[i] || period_ready) begin
                    m_valid[i] = 1'b1;
                    m_out[i]   = per;
                    m_ovf[i]   = (per == max_of[i]);
                end else begin
                    m_drop[i] = 1'b1;
                end
            end else if (m_valid[i] && period_ready) begin
                m_valid[i] = 1'b0;
            end
            m_stall[i] = (m_mode[i] == 2) && (u - m_last[i] + 1 >= max_of[i]);
            m_rise[i]  = hist[s-1] & ~hist[s];
        end
    endtask

    initial begin
        u = 0;
        model_reset();
        forever begin
            @(posedge clk_in or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    //-------------------------------------------------------------------------
    // Per-cycle compare against the model, plus a transfer log for u0
    //-------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk_in);
            for (int i = 0; i < 3; i++) begin
                chk("m_valid", i, longint'(p_valid[i]), longint'(m_valid[i]));
                if (m_valid[i]) begin
                    chk("m_period", i, get_out(i), m_out[i]);
                    chk("m_ovf", i, longint'(p_ovf[i]), longint'(m_ovf[i]));
                end
                chk("m_stalled", i, longint'(p_stalled[i]), longint'(m_stall[i]));
                chk("m_dropped", i, longint'(p_dropped[i]), longint'(m_drop[i]));
                chk("m_rise", i, longint'(rise_w[i]), longint'(m_rise[i]));
            end
            if (p_valid[0] && period_ready)
                $display("xfer u0 @%0t period=%0d ovf=%0b", $time, p_out0, p_ovf[0]);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    //-------------------------------------------------------------------------
    // Stimulus
    //-------------------------------------------------------------------------
    initial begin
        rst_n = 1'b0; sig_in = 1'b0; enable = 1'b0; period_ready = 1'b0;
        cyc(3);
        for (int i = 0; i < 3; i++) begin
            expect_buf(i, 0, 0, 0);
            chk("rst_out", i, get_out(i), 0);
            chk("rst_stalled", i, longint'(p_stalled[i]), 0);
        end
        rst_n = 1'b1;
        cyc(2);

        // Period 8 with ready held high; captures land S+1 posedges after the rise
        enable = 1'b1; period_ready = 1'b1;
        cyc(3);
        repeat (5) sig_period(4, 4);
        sig_in = 1'b1;
        cyc(3);
        chk("p8_valid", 0, longint'(p_valid[0]), 1);
        chk("p8_out", 0, get_out(0), 8);
        chk("p8_ovf", 0, longint'(p_ovf[0]), 0);
        cyc(1);
        chk("p8_valid", 1, longint'(p_valid[1]), 1);
        chk("p8_out", 1, get_out(1), 8);
        sig_in = 1'b0;
        cyc(1);
        chk("p8_valid", 2, longint'(p_valid[2]), 1);
        chk("p8_out", 2, get_out(2), 8);
        cyc(3);

        // Saturation of the 4-bit meters while sig_in stays low
        cyc(20);
        chk("stall_on", 0, longint'(p_stalled[0]), 0);
        chk("stall_on", 1, longint'(p_stalled[1]), 1);
        chk("stall_on", 2, longint'(p_stalled[2]), 1);
        sig_in = 1'b1;
        cyc(4);
        chk("sat_out", 1, get_out(1), 15);
        chk("sat_ovf", 1, longint'(p_ovf[1]), 1);
        chk("stall_off", 1, longint'(p_stalled[1]), 0);
        cyc(1);
        chk("sat_out", 2, get_out(2), 15);
        chk("sat_ovf", 2, longint'(p_ovf[2]), 1);
        chk("stall_off", 2, longint'(p_stalled[2]), 0);
        sig_in = 1'b0;
        cyc(4);

        // Fill the buffer (gap 9), drop a capture, then abort with enable=0
        period_ready = 1'b0;
        sig_period(3, 3);
        sig_period(3, 3);
        for (int i = 0; i < 3; i++) expect_buf(i, 1, 9, 1);
        enable = 1'b0;
        cyc(1);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_buf(i, 1, 9, 0);
            chk("abort_stall", i, longint'(p_stalled[i]), 0);
        end
        sig_period(3, 3);   // re-arm edge: must not capture
        for (int i = 0; i < 3; i++) expect_buf(i, 1, 9, 0);

        // Capture of 6 coinciding with valid && ready on u0
        sig_in = 1'b1;
        cyc(2);
        period_ready = 1'b1;
        cyc(1);
        period_ready = 1'b0;
        expect_buf(0, 1, 6, 0);
        sig_in = 1'b0;
        cyc(3);
        for (int i = 0; i < 3; i++) expect_buf(i, 1, 6, 0);

        // Backpressure across captures of period 10
        period_ready = 1'b1;
        cyc(1);
        period_ready = 1'b0;
        for (int i = 0; i < 3; i++) chk("drain", i, longint'(p_valid[i]), 0);
        period_ready = 1'b1;
        repeat (2) sig_period(5, 5);
        period_ready = 1'b0;
        repeat (3) sig_period(5, 5);
        for (int i = 0; i < 3; i++) expect_buf(i, 1, 10, 1);
        sig_in = 1'b1;
        cyc(5);
        sig_in = 1'b0;
        period_ready = 1'b1;
        cyc(1);
        period_ready = 1'b0;
        for (int i = 0; i < 3; i++) chk("pulse_drain", i, longint'(p_valid[i]), 0);
        cyc(4);
        sig_period(5, 5);
        for (int i = 0; i < 3; i++) expect_buf(i, 1, 10, 1);

        // Asynchronous reset mid-count
        cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("arst_valid", i, longint'(p_valid[i]), 0);
            chk("arst_out", i, get_out(i), 0);
            chk("arst_ovf", i, longint'(p_ovf[i]), 0);
            chk("arst_stalled", i, longint'(p_stalled[i]), 0);
            chk("arst_dropped", i, longint'(p_dropped[i]), 0);
        end
        @(negedge clk_in);
        cyc(1);
        rst_n = 1'b1;

        // Edge-detect latency: sig_in driven after posedge 0 is acted on at
        // posedge S+1, so rise is high in the cycle just before it
        cyc(6);
        sig_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            for (int i = 0; i < 3; i++)
                chk("rise_latency", i, longint'(rise_w[i]), (k == s_of[i]) ? 1 : 0);
        end
        sig_in = 1'b0;
        cyc(6);

        // Random phase
        for (int n = 0; n < 300; n++) begin
            int hi;
            int lo;
            hi = int'($urandom_range(1, 12));
            if ($urandom_range(0, 9) == 0) lo = int'($urandom_range(16, 30));
            else                           lo = int'($urandom_range(1, 12));
            sig_in = 1'b1;
            for (int k = 0; k < hi; k++) begin
                period_ready = 1'($urandom_range(0, 1));
                enable = ($urandom_range(0, 49) != 0);
                @(negedge clk_in);
            end
            sig_in = 1'b0;
            for (int k = 0; k < lo; k++) begin
                period_ready = 1'($urandom_range(0, 1));
                enable = ($urandom_range(0, 49) != 0);
                @(negedge clk_in);
            end
        end

        cyc(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
